// File: rtl/wb_regfile_pkg.sv
// y86_pkg: shared Y86-64 definitions for the write-back stage and the decode stage.
//   icode_e    : instruction codes I_HALT .. I_POPQ
//   R_NONE     : register specifier meaning "no register"
//   R_RSP      : architectural stack-pointer index
//   dst_t      : decoded write destinations (dst_e from valE, dst_m from valM)
//   dst_decode : icode/cnd/rA/rB -> dst_t, shared with decode-stage srcA/srcB logic
package y86_pkg;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    typedef struct packed {
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } dst_t;

    // rsp_idx/rnone are arguments so parametrised register files can reuse this.
    function automatic dst_t dst_decode(
        input logic [3:0] icode,
        input logic       cnd,
        input logic [3:0] ra,
        input logic [3:0] rb,
        input logic [3:0] rsp_idx,
        input logic [3:0] rnone
    );
        dst_t d;
        d.dst_e = rnone;
        d.dst_m = rnone;
        case (icode)
            I_IRMOVQ, I_OPQ:                d.dst_e = rb;
            I_RRMOVQ:                       d.dst_e = cnd ? rb : rnone;
            I_CALL, I_RET, I_PUSHQ, I_POPQ: d.dst_e = rsp_idx;
            default:                        d.dst_e = rnone;
        endcase
        case (icode)
            I_MRMOVQ, I_POPQ: d.dst_m = ra;
            default:          d.dst_m = rnone;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back commit bus plus the two register read ports.
//   master (pipeline side): drives wb_valid, icode, cnd, rA, rB, valE, valM,
//                           raddr_a, raddr_b; receives rdata_a, rdata_b
//   slave  (register file): the reverse
interface wb_regfile_if #(
    parameter int unsigned DATA_W = 64
);
    logic              wb_valid;
    logic [3:0]        icode;
    logic              cnd;
    logic [3:0]        rA;
    logic [3:0]        rB;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [3:0]        raddr_a;
    logic [3:0]        raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    modport master (
        output wb_valid, icode, cnd, rA, rB, valE, valM, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  wb_valid, icode, cnd, rA, rB, valE, valM, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/wb_regfile_dst_decode.sv
// wb_dst_decode: combinational write-destination decode.
//   icode, cnd, rA, rB : instruction fields in write-back
//   dstE               : destination for valE (RNONE if none)
//   dstM               : destination for valM (RNONE if none)
module wb_dst_decode
    import y86_pkg::*;
#(
    parameter logic [3:0] RNONE   = R_NONE,
    parameter logic [3:0] RSP_IDX = R_RSP
) (
    input  logic [3:0] icode,
    input  logic       cnd,
    input  logic [3:0] rA,
    input  logic [3:0] rB,
    output logic [3:0] dstE,
    output logic [3:0] dstM
);
    dst_t d;

    always_comb begin
        d    = dst_decode(icode, cnd, rA, rB, RSP_IDX, RNONE);
        dstE = d.dst_e;
        dstM = d.dst_m;
    end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: Y86-64 write-back stage with internal register file.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : commit bus (wb_valid/icode/cnd/rA/rB/valE/valM) and two
//                read ports (raddr_a/b -> rdata_a/b, 0 for addr >= NREGS)
//   reg_flat   : register i at [i*DATA_W +: DATA_W]
//   retired    : committed-instruction count, wraps
//   halted     : sticky, HALT committed
//   err        : sticky, illegal icode seen
module wb_regfile
    import y86_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       NREGS    = 15,
    parameter int unsigned       RNONE    = 15,
    parameter int unsigned       RSP_IDX  = 4,
    parameter logic [DATA_W-1:0] RSP_INIT = '0,
    parameter bit                BYPASS   = 1'b1,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wb_regfile_if.slave             bus,
    output logic [DATA_W*NREGS-1:0] reg_flat,
    output logic [CNT_W-1:0]        retired,
    output logic                    halted,
    output logic                    err
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic              commit;
    logic              illegal;
    logic [3:0]        raddr [2];
    logic [DATA_W-1:0] rdata [2];

    wb_dst_decode #(
        .RNONE   (4'(RNONE)),
        .RSP_IDX (4'(RSP_IDX))
    ) u_dst (
        .icode (bus.icode),
        .cnd   (bus.cnd),
        .rA    (bus.rA),
        .rB    (bus.rB),
        .dstE  (dst_e),
        .dstM  (dst_m)
    );

    // rst_n gates commit so the bypass path never exposes a write that reset discards.
    always_comb begin
        commit  = rst_n && bus.wb_valid && !halted && !err && (bus.icode <= I_POPQ);
        illegal = bus.wb_valid && (bus.icode > I_POPQ);
    end

    // Destinations >= NREGS never match an index, so they are dropped naturally.
    // Checking dst_m first makes valM win when both ports hit the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
        end else if (commit) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (dst_m == 4'(i))
                    regs[i] <= bus.valM;
                else if (dst_e == 4'(i))
                    regs[i] <= bus.valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            halted  <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (commit) begin
                retired <= retired + CNT_W'(1);
                if (bus.icode == I_HALT)
                    halted <= 1'b1;
            end
            if (illegal)
                err <= 1'b1;
        end
    end

    always_comb begin
        raddr[0] = bus.raddr_a;
        raddr[1] = bus.raddr_b;
        for (int unsigned p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (32'(raddr[p]) < NREGS) begin
                if (BYPASS && commit && dst_m == raddr[p])
                    rdata[p] = bus.valM;
                else if (BYPASS && commit && dst_e == raddr[p])
                    rdata[p] = bus.valE;
                else
                    rdata[p] = regs[raddr[p]];
            end
        end
        bus.rdata_a = rdata[0];
        bus.rdata_b = rdata[1];
    end

    always_comb begin
        reg_flat = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            reg_flat[i*DATA_W +: DATA_W] = regs[i];
    end
endmodule
